// File: rtl/block_put.sv
// block_put: writes a JxK result block back into a row-major matrix, one element per slot, skipping out-of-bounds elements.
// Optional BLOCK_PUT_ACCUM_EN: read-modify-write accumulate (READ then WRITE cycle per element).
`ifndef J
`define J 2
`endif
`ifndef K
`define K 2
`endif
`ifndef DATA_W
`define DATA_W 16
`endif

module block_put #(
   parameter int unsigned J      = `J,
   parameter int unsigned K      = `K,
   parameter int unsigned DATA_W = `DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [9:0]        start_row,
   input  logic [9:0]        start_col,
   input  logic [9:0]        num_cols,
   input  logic [9:0]        matrix_len,
   input  logic [DATA_W-1:0] block [0:J*K-1],
`ifdef BLOCK_PUT_ACCUM_EN
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_re,
`endif
   output logic              mem_we,
   output logic [9:0]        mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              busy,
   output logic              block_put_done
);
   localparam int unsigned N     = J * K;
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned POS_W = 11;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  idx, idx_nxt;
   logic [DATA_W-1:0] blk_q [0:N-1];
   logic [9:0]        row_q, col_q, ncol_q, rows_q;
   logic              cap;
   logic              we_nxt, busy_nxt, done_nxt;
   logic [9:0]        addr_nxt;
   logic [DATA_W-1:0] wdata_nxt;
   logic [POS_W-1:0]  row_c, col_c;
   logic              in_bounds_c, last_c;
   logic [9:0]        addr_c, rows_c;
`ifdef BLOCK_PUT_ACCUM_EN
   logic              phase, phase_nxt, re_nxt;
`endif

   // Position of the current element; sums kept 11 bits wide so the bound compare cannot wrap.
   always_comb begin
      row_c       = POS_W'(row_q) + POS_W'(32'(idx) / K);
      col_c       = POS_W'(col_q) + POS_W'(32'(idx) % K);
      in_bounds_c = (ncol_q != 10'd0) && (row_c < POS_W'(rows_q)) && (col_c < POS_W'(ncol_q));
      addr_c      = 10'(row_c * POS_W'(ncol_q) + col_c);
      last_c      = (idx == IDX_W'(N - 1));
      rows_c      = (num_cols == 10'd0) ? 10'd0 : matrix_len / num_cols;
   end

   // Next state and next registered outputs.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cap       = 1'b0;
      we_nxt    = 1'b0;
      addr_nxt  = mem_addr;
      wdata_nxt = mem_wdata;
      done_nxt  = 1'b0;
`ifdef BLOCK_PUT_ACCUM_EN
      phase_nxt = phase;
      re_nxt    = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (start) begin
               cap       = 1'b1;
               idx_nxt   = '0;
               state_nxt = RUN;
`ifdef BLOCK_PUT_ACCUM_EN
               phase_nxt = 1'b0;
`endif
            end
         end
         RUN: begin
            addr_nxt = addr_c;
`ifdef BLOCK_PUT_ACCUM_EN
            if (!phase) begin
               re_nxt    = in_bounds_c;
               phase_nxt = 1'b1;
            end else begin
               we_nxt    = in_bounds_c;
               wdata_nxt = mem_rdata + blk_q[idx];
               phase_nxt = 1'b0;
               if (last_c) state_nxt = DONE;
               else        idx_nxt   = idx + IDX_W'(1);
            end
`else
            we_nxt    = in_bounds_c;
            wdata_nxt = blk_q[idx];
            if (last_c) state_nxt = DONE;
            else        idx_nxt   = idx + IDX_W'(1);
`endif
         end
         DONE: begin
            done_nxt  = 1'b1;
            idx_nxt   = '0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   // State, output and capture registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         idx            <= '0;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_wdata      <= '0;
         busy           <= 1'b0;
         block_put_done <= 1'b0;
         blk_q          <= '{default: '0};
         row_q          <= '0;
         col_q          <= '0;
         ncol_q         <= '0;
         rows_q         <= '0;
`ifdef BLOCK_PUT_ACCUM_EN
         phase          <= 1'b0;
         mem_re         <= 1'b0;
`endif
      end else begin
         state          <= state_nxt;
         idx            <= idx_nxt;
         mem_we         <= we_nxt;
         mem_addr       <= addr_nxt;
         mem_wdata      <= wdata_nxt;
         busy           <= busy_nxt;
         block_put_done <= done_nxt;
`ifdef BLOCK_PUT_ACCUM_EN
         phase          <= phase_nxt;
         mem_re         <= re_nxt;
`endif
         if (cap) begin
            blk_q  <= block;
            row_q  <= start_row;
            col_q  <= start_col;
            ncol_q <= num_cols;
            rows_q <= rows_c;
         end
      end
   end

endmodule

// File: tb/tb_block_put.sv
// Scoreboard bench for block_put: the driver queues expected memory events, a negedge monitor pops and compares them.
module tb_block_put;
   localparam int unsigned J  = 2;
   localparam int unsigned K  = 2;
   localparam int unsigned DW = 16;
   localparam int N = 4;
`ifdef BLOCK_PUT_ACCUM_EN
   localparam int L = 2;
`else
   localparam int L = 1;
`endif

   typedef enum int {EV_RD, EV_WR, EV_DONE} ev_t;
   typedef struct {
      ev_t kind;
      int  cyc;
      int  addr;
      int  data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [9:0]    start_row = '0, start_col = '0, num_cols = '0, matrix_len = '0;
   logic [DW-1:0] blk [0:N-1];
   logic          mem_we, busy, block_put_done;
   logic [9:0]    mem_addr;
   logic [DW-1:0] mem_wdata;
`ifdef BLOCK_PUT_ACCUM_EN
   logic          mem_re;
   logic [DW-1:0] mem_rdata;
   assign mem_rdata = (mem_addr == 10'd0) ? 16'd10 : 16'd0;
`endif

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   vb [4];
   int   va [4];
   int   vd [4];

   block_put #(.J(J), .K(K), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .start_row(start_row), .start_col(start_col),
      .num_cols(num_cols), .matrix_len(matrix_len), .block(blk),
`ifdef BLOCK_PUT_ACCUM_EN
      .mem_rdata(mem_rdata), .mem_re(mem_re),
`endif
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .block_put_done(block_put_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_evt(input ev_t kind, input int addr, input int data);
      exp_t e;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind %0d addr %0d data %0d in cycle %0d, required no event",
                  kind, addr, data, cyc);
         return;
      end
      e = q.pop_front();
      if (e.kind != kind || e.cyc != cyc || (kind != EV_DONE && e.addr != addr) ||
          (kind == EV_WR && e.data != data)) begin
         errors++;
         $display("FAIL event: got kind %0d cyc %0d addr %0d data %0d, required kind %0d cyc %0d addr %0d data %0d",
                  kind, cyc, addr, data, e.kind, e.cyc, e.addr, e.data);
      end
   endtask

   // Monitor: every strobe or done pulse must match the head of the queue.
   always @(negedge clk) begin
      if (!rst) begin
`ifdef BLOCK_PUT_ACCUM_EN
         if (mem_re) check_evt(EV_RD, int'(mem_addr), 0);
`endif
         if (mem_we) check_evt(EV_WR, int'(mem_addr), int'(mem_wdata));
         if (block_put_done) check_evt(EV_DONE, 0, 0);
      end
   end

   task automatic check(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask

   // Pulses start with vb/va/vd; queues events whose cycle (relative to the start edge) is <= cut.
   task automatic issue(input int r, input int c, input int nc, input int ml, input int cut);
      int base;
      int acc;
      @(negedge clk);
      start_row  = 10'(r);
      start_col  = 10'(c);
      num_cols   = 10'(nc);
      matrix_len = 10'(ml);
      for (int s = 0; s < N; s++) blk[s] = 16'(vb[s]);
      start = 1'b1;
      base  = cyc + 1;
      for (int s = 0; s < N; s++) begin
         if (va[s] >= 0) begin
            acc = (L == 2 && va[s] == 0) ? 10 : 0;
            if (L == 2 && 2 * s + 1 <= cut) q.push_back('{EV_RD, base + 2 * s + 1, va[s], 0});
            if (L * (s + 1) <= cut) q.push_back('{EV_WR, base + L * (s + 1), va[s], (vd[s] + acc) % 65536});
         end
      end
      if (L * N + 1 <= cut) q.push_back('{EV_DONE, base + L * N + 1, 0, 0});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected events never seen, required 0", q.size());
         q.delete();
      end
   endtask

   initial begin
      for (int s = 0; s < N; s++) blk[s] = '0;
      #1;
      check("reset_mem_we", int'(mem_we), 0);
      check("reset_mem_addr", int'(mem_addr), 0);
      check("reset_mem_wdata", int'(mem_wdata), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(block_put_done), 0);
`ifdef BLOCK_PUT_ACCUM_EN
      check("reset_mem_re", int'(mem_re), 0);
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Full in-bounds block at the origin.
      vb = '{1, 2, 3, 4}; va = '{0, 1, 3, 4}; vd = '{1, 2, 3, 4};
      issue(0, 0, 3, 9, 1000);
      drain();

      // Bottom-right corner: only the first element lands.
      vb = '{5, 6, 7, 8}; va = '{8, -1, -1, -1}; vd = '{5, 6, 7, 8};
      issue(2, 2, 3, 9, 1000);
      drain();

      // Interior block.
      vb = '{100, 200, 300, 400}; va = '{4, 5, 7, 8}; vd = '{100, 200, 300, 400};
      issue(1, 1, 3, 9, 1000);
      drain();

      // 2x4 matrix, last column of last row.
      vb = '{11, 22, 33, 44}; va = '{7, -1, -1, -1}; vd = '{11, 22, 33, 44};
      issue(1, 3, 4, 8, 1000);
      drain();

      // Re-pulsed start and changed block while busy are ignored.
      vb = '{1, 2, 3, 4}; va = '{0, 1, 3, 4}; vd = '{1, 2, 3, 4};
      issue(0, 0, 3, 9, 1000);
      for (int c = 1; c <= L * N + 1; c++) begin
         @(negedge clk);
         check($sformatf("busy_cycle%0d", c), int'(busy), (c <= L * N) ? 1 : 0);
         if (c == 2) begin
            start = 1'b1;
            for (int s = 0; s < N; s++) blk[s] = 16'd9;
            start_row = 10'd1;
         end else begin
            start = 1'b0;
         end
      end
      drain();

      // Reset in cycle 2 aborts the block.
      vb = '{1, 2, 3, 4}; va = '{0, 1, 3, 4}; vd = '{1, 2, 3, 4};
      issue(0, 0, 3, 9, 1);
      @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("abort_mem_we", int'(mem_we), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(block_put_done), 0);
      @(negedge clk);
      rst = 1'b0;
      drain();
      issue(0, 0, 3, 9, 1000);
      drain();

      // Zero columns: no writes, normal done timing.
      vb = '{1, 2, 3, 4}; va = '{-1, -1, -1, -1}; vd = '{1, 2, 3, 4};
      issue(0, 0, 0, 9, 1000);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at 200000, required finish");
      $fatal(1, "timeout");
   end
endmodule
